ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  PS/2 host-to-device transmitter: sends one command byte (LED set 0xED, reset 0xFF,
//  enable 0xF4, ...) from the Z88 side to the keyboard over the open-drain clock/data pair.
//  Counterpart of the keyboard receiver. It shares the same ps2clk/ps2dat pins and has
//  priority over the receiver while busy. The pads are wired as tri-states: drive 0 when *_oe=1, else Z.
// PARAMETERS
//  INHIBIT_CYC  1024    clk cycles ps2clk is held low before start (>=100us @9.8304MHz)
//  TIMEOUT_CYC  196608  max clk cycles between device clock falling edges (20ms)
//  FILTER_LEN   4       consecutive equal synchronised samples to accept a line level
// PORTS
//  clk        in   1  master clock (z88 mck)
//  reset      in   1  asynchronous, active-high reset
//  tx_data    in   8  command byte, sampled on accept
//  tx_valid   in   1  request; accepted when tx_valid & tx_ready
//  tx_ready   out  1  1 only in IDLE
//  ps2clk_i   in   1  raw PS/2 clock pin level
//  ps2dat_i   in   1  raw PS/2 data pin level
//  ps2clk_oe  out  1  1 = pull PS/2 clock low
//  ps2dat_oe  out  1  1 = pull PS/2 data low
//  busy       out  1  transfer in progress (receiver must discard frames)
//  done       out  1  one-cycle pulse: byte sent and acknowledged
//  err        out  1  one-cycle pulse: transfer failed
//  err_code   out  2  valid with err: 01 timeout, 10 no ack; held until next err
// BEHAVIOUR
//  Reset (async): state IDLE; ps2clk_oe=ps2dat_oe=busy=done=err=0; err_code=00;
//   tx_ready=1. Lines released immediately on reset, including mid-transfer.
//  Line inputs: 2-FF synchroniser, then FILTER_LEN glitch filter. fall = filtered clk 1->0.
//  States / transitions (all outputs registered):
//   IDLE: accept at cycle N -> INHIBIT; latch data; parity = ~^tx_data (odd).
//   INHIBIT: ps2clk_oe=1 from N+1 for INHIBIT_CYC cycles. In the last cycle ps2dat_oe=1.
//    -> START.
//   START: ps2clk_oe=0, ps2dat_oe=1 (start bit). Wait for fall.
//   DATA: on each fall drive bit i (LSB first, i=0..7): ps2dat_oe = ~bit.
//   PARITY: on the 9th fall drive the parity bit.
//   STOP: on the 10th fall ps2dat_oe=0 (stop=1).
//   ACK: on the 11th fall sample data: 0 = ack, 1 = no-ack.
//   WAIT_IDLE: wait until filtered clk=1 & dat=1. Then done (ack) or err/10 (no-ack).
//    -> IDLE.
//  Falls seen during INHIBIT are ignored. Edge detection is armed only from START.
//  Timeout: a cycle counter clears on every fall and on entering START. Reaching
//   TIMEOUT_CYC in START..WAIT_IDLE -> release both lines, err=1, err_code=01, IDLE.
//  busy = (state != IDLE). tx_valid while busy is ignored (tx_ready=0). No queueing.
//  done and err are mutually exclusive.
//  A receiver frame in progress at accept is aborted by the inhibit. This is intended.
//  Counter widths come from $clog2 of the parameters. Bit index is 4 bits, saturating at 11.
// STRUCTURE
//  Package z88_ps2_pkg: state enum; ERR_NONE/ERR_TIMEOUT/ERR_NOACK constants;
//   odd_parity(byte) function; PS/2 command constants (0xED, 0xF4, 0xFF).
//   The receiver shares this package.
//  Sub-module ps2_line_filt: sync + glitch filter + fall pulse. One instance per line.
//  Top level: FSM, bit/inhibit/timeout counters, shift register.
// TESTING (device BFM: ~12.5kHz clock, samples data on rising edge, drives ack)
//  1. tx_data=0xED, BFM acks -> bits 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulse;
//     err=0; ps2clk_oe high for exactly INHIBIT_CYC cycles.
//  2. tx_data=0xF4 -> bits 0,0,1,0,1,1,1,1, parity 0; done.
//     tx_ready=0 from accept+1 until return to IDLE.
//  3. tx_data=0xFF, BFM leaves data high at ack -> err pulse, err_code=10, no done.
//  4. BFM stops clocking after bit 3 -> err at TIMEOUT_CYC after last fall;
//     err_code=01; both oe=0.
//  5. reset asserted mid-DATA -> ps2clk_oe=ps2dat_oe=0 with no clock edge.
//     tx_ready=1 after release. Next 0x01 sends cleanly (parity 0).
//  6. 1-cycle glitches on ps2clk_i (< FILTER_LEN) during DATA -> no extra bit shifted;
//     frame 0x00 still correct (parity 1).

Source files
------------

// File: rtl/z88_ps2_pkg.sv
// Shared PS/2 definitions for the Z88 keyboard interface (host transmitter and
// keyboard receiver): transmitter state encoding, error codes, the odd parity
// helper and the common host command bytes.
package z88_ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_START     = 3'd2,
    ST_DATA      = 3'd3,
    ST_PARITY    = 3'd4,
    ST_STOP      = 3'd5,
    ST_ACK       = 3'd6,
    ST_WAIT_IDLE = 3'd7
  } tx_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NOACK   = 2'b10;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // Parity bit that makes the total count of ones in byte+parity odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~(^b);
  endfunction

endpackage

// File: rtl/ps2_line_filt.sv
// One PS/2 line conditioner: 2-FF synchroniser, glitch filter that only accepts
// a new level after FILTER_LEN consecutive equal synchronised samples, and a
// one-cycle pulse on every accepted 1->0 transition.
// Ports:
//   clk, reset : master clock, asynchronous active-high reset
//   line       : raw pin level
//   level      : filtered level (idles high)
//   fall       : one-cycle pulse when level goes 1->0
module ps2_line_filt #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic level,
  output logic fall
);

  logic [1:0]            sync;
  logic [FILTER_LEN-1:0] hist;
  logic [FILTER_LEN-1:0] hist_next;

  assign hist_next = {hist[FILTER_LEN-2:0], sync[1]};

  // Synchronise, shift sample history, update filtered level and fall pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= 2'b11;
      hist  <= {FILTER_LEN{1'b1}};
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], line};
      hist <= hist_next;
      if (&hist_next) begin
        level <= 1'b1;
        fall  <= 1'b0;
      end else if (~|hist_next) begin
        level <= 1'b0;
        fall  <= level;
      end else begin
        fall  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, issues a start bit, then
// clocks out 8 data bits (LSB first), odd parity and stop on the device-generated
// clock, checks the device ack and waits for the bus to return idle.
// Ports:
//   clk, reset          : master clock, asynchronous active-high reset
//   tx_data/valid/ready : command byte handshake (ready only in IDLE)
//   ps2clk_i, ps2dat_i  : raw pin levels
//   ps2clk_oe, ps2dat_oe: 1 = pull the line low (open drain)
//   busy                : transfer in progress, receiver must discard frames
//   done, err           : one-cycle completion / failure pulses
//   err_code            : 01 timeout, 10 no ack; held until the next err
module ps2_host_tx
  import z88_ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = 1024,
  parameter int TIMEOUT_CYC = 196608,
  parameter int FILTER_LEN  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2clk_i,
  input  logic       ps2dat_i,
  output logic       ps2clk_oe,
  output logic       ps2dat_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int INH_W = $clog2(INHIBIT_CYC);
  localparam int TO_W  = $clog2(TIMEOUT_CYC);
  localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYC - 2);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  tx_state_t        state;
  logic [8:0]       shreg;
  logic [3:0]       bit_idx;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             ack;
  logic             armed;
  logic             clk_lvl;
  logic             clk_fall;
  logic             dat_lvl;
  logic             dat_fall_unused;

  ps2_line_filt #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk   (clk),
    .reset (reset),
    .line  (ps2clk_i),
    .level (clk_lvl),
    .fall  (clk_fall)
  );

  ps2_line_filt #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk   (clk),
    .reset (reset),
    .line  (ps2dat_i),
    .level (dat_lvl),
    .fall  (dat_fall_unused)
  );

  // Device clock edges only matter once our own inhibit pulse is over.
  assign armed = (state != ST_IDLE) && (state != ST_INHIBIT);

  // Watchdog: cycles since the last device clock fall (or since START).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= {TO_W{1'b0}};
    end else if (!armed || clk_fall) begin
      to_cnt <= {TO_W{1'b0}};
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Transfer FSM with registered bus and handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      shreg     <= 9'd0;
      bit_idx   <= 4'd0;
      inh_cnt   <= {INH_W{1'b0}};
      ack       <= 1'b0;
      ps2clk_oe <= 1'b0;
      ps2dat_oe <= 1'b0;
      busy      <= 1'b0;
      tx_ready  <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (clk_fall && armed && (bit_idx != 4'd11)) begin
        bit_idx <= bit_idx + 4'd1;
      end
      case (state)
        ST_IDLE: begin
          ps2clk_oe <= 1'b0;
          ps2dat_oe <= 1'b0;
          if (tx_valid) begin
            state     <= ST_INHIBIT;
            shreg     <= {odd_parity(tx_data), tx_data};
            bit_idx   <= 4'd0;
            inh_cnt   <= {INH_W{1'b0}};
            ps2clk_oe <= 1'b1;
            busy      <= 1'b1;
            tx_ready  <= 1'b0;
          end
        end
        ST_INHIBIT: begin
          inh_cnt <= inh_cnt + INH_W'(1);
          // Start bit overlaps the final inhibit cycle so data is already low
          // when the clock is released.
          if (inh_cnt == INH_PRE) begin
            ps2dat_oe <= 1'b1;
          end
          if (inh_cnt == INH_LAST) begin
            ps2clk_oe <= 1'b0;
            state     <= ST_START;
          end
        end
        ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_ACK: begin
          if (clk_fall) begin
            case (state)
              ST_START: begin
                ps2dat_oe <= ~shreg[0];
                shreg     <= {1'b0, shreg[8:1]};
                state     <= ST_DATA;
              end
              ST_DATA: begin
                ps2dat_oe <= ~shreg[0];
                shreg     <= {1'b0, shreg[8:1]};
                if (bit_idx == 4'd7) begin
                  state <= ST_PARITY;
                end
              end
              ST_PARITY: begin
                ps2dat_oe <= ~shreg[0];
                shreg     <= {1'b0, shreg[8:1]};
                state     <= ST_STOP;
              end
              ST_STOP: begin
                ps2dat_oe <= 1'b0;
                state     <= ST_ACK;
              end
              default: begin
                ack   <= ~dat_lvl;
                state <= ST_WAIT_IDLE;
              end
            endcase
          end else if (to_cnt == TO_LAST) begin
            state     <= ST_IDLE;
            ps2clk_oe <= 1'b0;
            ps2dat_oe <= 1'b0;
            busy      <= 1'b0;
            tx_ready  <= 1'b1;
            err       <= 1'b1;
            err_code  <= ERR_TIMEOUT;
          end
        end
        ST_WAIT_IDLE: begin
          if (clk_lvl && dat_lvl) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
            if (ack) begin
              done <= 1'b1;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_NOACK;
            end
          end else if (to_cnt == TO_LAST) begin
            state     <= ST_IDLE;
            ps2clk_oe <= 1'b0;
            ps2dat_oe <= 1'b0;
            busy      <= 1'b0;
            tx_ready  <= 1'b1;
            err       <= 1'b1;
            err_code  <= ERR_TIMEOUT;
          end
        end
        default: begin
          state     <= ST_IDLE;
          ps2clk_oe <= 1'b0;
          ps2dat_oe <= 1'b0;
          busy      <= 1'b0;
          tx_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model driving the
// device clock and sampling data on its rising edge.
module tb_ps2_host_tx;

  localparam int INH  = 16;
  localparam int TO   = 200;
  localparam int FL   = 4;
  localparam int HALF = 20;

  localparam int M_ACK   = 0;
  localparam int M_NOACK = 1;
  localparam int M_STALL = 2;
  localparam int M_RESET = 3;
  localparam int M_GLTCH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2clk_i;
  logic       ps2dat_i;
  logic       ps2clk_oe;
  logic       ps2dat_oe;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  logic bfm_clk = 1'b1;
  logic bfm_dat = 1'b1;
  logic glitch  = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int run = 0;
  int last_run = 0;
  int ready_viol = 0;
  int last_fall_cyc = 0;

  // open-drain bus: device and host both can only pull low
  assign ps2clk_i = bfm_clk & ~ps2clk_oe & ~glitch;
  assign ps2dat_i = bfm_dat & ~ps2dat_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO), .FILTER_LEN(FL)) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .ps2clk_i  (ps2clk_i),
    .ps2dat_i  (ps2dat_i),
    .ps2clk_oe (ps2clk_oe),
    .ps2dat_oe (ps2dat_oe),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // pulse counters, inhibit run length and ready/busy consistency
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (ps2clk_oe) begin
      run <= run + 1;
    end else begin
      if (run != 0) last_run <= run;
      run <= 0;
    end
    if (!reset && (tx_ready === busy)) ready_viol <= ready_viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    chk("accept_ready", {31'd0, tx_ready}, 32'd0);
    chk("accept_clkoe", {31'd0, ps2clk_oe}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 500) begin
      tick(1);
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  // Device model: waits for request-to-send, clocks 11 bits, samples data on
  // each rising edge; mode selects ack/no-ack/stall/reset/glitch behaviour.
  task automatic bfm_frame(input int mode, output logic [7:0] data, output logic par,
                           output logic stp);
    logic [10:0] rec;
    int n;
    rec = 11'h7FF;
    n = 0;
    while (!(ps2clk_i === 1'b1 && ps2dat_i === 1'b0) && n < 3000) begin
      tick(1);
      n++;
    end
    chk("rts_seen", {31'd0, (n < 3000)}, 32'd1);
    if (n < 3000) begin
      tick(10);
      for (int k = 0; k < 11; k++) begin
        if (k == 10 && mode != M_NOACK) begin
          bfm_dat = 1'b0;
          tick(5);
        end
        bfm_clk = 1'b0;
        last_fall_cyc = cyc;
        tick(HALF);
        bfm_clk = 1'b1;
        rec[k] = ps2dat_i;
        if ((mode == M_STALL && k == 3) || (mode == M_RESET && k == 2)) break;
        if (mode == M_GLTCH && k >= 1 && k <= 7) begin
          tick(HALF / 2);
          glitch = 1'b1;
          tick(1);
          glitch = 1'b0;
          tick(HALF - HALF / 2 - 1);
        end else begin
          tick(HALF);
        end
        if (k == 10) bfm_dat = 1'b1;
      end
    end
    data = rec[7:0];
    par  = rec[8];
    stp  = rec[9];
  endtask

  initial begin
    logic [7:0] d;
    logic p;
    logic s;
    int dc;
    int ec;
    int n;

    // reset state
    #12;
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_clkoe", {31'd0, ps2clk_oe}, 32'd0);
    chk("rst_datoe", {31'd0, ps2dat_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_code", {30'd0, err_code}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick(5);

    // 1: 0xED acked
    dc = done_cnt; ec = err_cnt;
    send(8'hED);
    bfm_frame(M_ACK, d, p, s);
    wait_idle("t1_idle");
    tick(2);
    chk("t1_data", {24'd0, d}, 32'hED);
    chk("t1_parity", {31'd0, p}, 32'd1);
    chk("t1_stop", {31'd0, s}, 32'd1);
    chk("t1_done", done_cnt - dc, 32'd1);
    chk("t1_noerr", err_cnt - ec, 32'd0);
    chk("t1_inhibit_len", last_run, INH);

    // 2: 0xF4 acked, ready low throughout
    dc = done_cnt;
    send(8'hF4);
    bfm_frame(M_ACK, d, p, s);
    wait_idle("t2_idle");
    tick(2);
    chk("t2_data", {24'd0, d}, 32'hF4);
    chk("t2_parity", {31'd0, p}, 32'd0);
    chk("t2_done", done_cnt - dc, 32'd1);
    chk("t2_ready_vs_busy", ready_viol, 32'd0);

    // 3: 0xFF not acked
    dc = done_cnt; ec = err_cnt;
    send(8'hFF);
    bfm_frame(M_NOACK, d, p, s);
    wait_idle("t3_idle");
    tick(2);
    chk("t3_data", {24'd0, d}, 32'hFF);
    chk("t3_err", err_cnt - ec, 32'd1);
    chk("t3_code", {30'd0, err_code}, 32'd2);
    chk("t3_nodone", done_cnt - dc, 32'd0);

    // 4: device stalls after bit 3
    ec = err_cnt;
    send(8'h5A);
    bfm_frame(M_STALL, d, p, s);
    n = 0;
    while (err_cnt == ec && n < 1000) begin
      tick(1);
      n++;
    end
    tick(1);
    chk("t4_err", err_cnt - ec, 32'd1);
    chk("t4_window", {31'd0, ((err_cyc - last_fall_cyc) >= TO) &&
                             ((err_cyc - last_fall_cyc) <= TO + 12)}, 32'd1);
    chk("t4_code", {30'd0, err_code}, 32'd1);
    chk("t4_oe", {30'd0, ps2clk_oe, ps2dat_oe}, 32'd0);
    chk("t4_ready", {31'd0, tx_ready}, 32'd1);

    // 5: reset mid-DATA, then a clean 0x01
    send(8'hA5);
    bfm_frame(M_RESET, d, p, s);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_oe_async", {30'd0, ps2clk_oe, ps2dat_oe}, 32'd0);
    chk("t5_busy_async", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick(5);
    chk("t5_ready", {31'd0, tx_ready}, 32'd1);
    dc = done_cnt;
    send(8'h01);
    bfm_frame(M_ACK, d, p, s);
    wait_idle("t5_idle");
    tick(2);
    chk("t5_data", {24'd0, d}, 32'h01);
    chk("t5_parity", {31'd0, p}, 32'd0);
    chk("t5_done", done_cnt - dc, 32'd1);

    // 6: 1-cycle clock glitches during data bits
    dc = done_cnt; ec = err_cnt;
    send(8'h00);
    bfm_frame(M_GLTCH, d, p, s);
    wait_idle("t6_idle");
    tick(2);
    chk("t6_data", {24'd0, d}, 32'h00);
    chk("t6_parity", {31'd0, p}, 32'd1);
    chk("t6_stop", {31'd0, s}, 32'd1);
    chk("t6_done", done_cnt - dc, 32'd1);
    chk("t6_noerr", err_cnt - ec, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
